// File: rtl/cpu_bus_seq.sv
// Master for a multiplexed CPU address/data bus: one request per handshake, then an
// address cycle, a data phase (wait states, read bursts, per-beat timeout) and a turnaround.
`timescale 1ns/1ps
module cpu_bus_seq #(
    parameter int  AW        = 32,
    parameter int  BURST_MAX = 4,
    parameter int  TO_CYCLES = 16,
    localparam int LW        = $clog2(BURST_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [LW-1:0] req_len,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_err,
    output logic          rsp_last,
    output logic          bus_adrcy_o,
    output logic [31:0]   bus_ad_o,
    output logic          bus_ad_oe,
    input  logic [31:0]   bus_ad_i,
    output logic          bus_tm1n_o,
    output logic          bus_tm0n_o,
    input  logic          bus_ackn_i
);

    localparam int            TW       = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYCLES - 1);
    localparam logic [1:0]    ERR_OK   = 2'b00;
    localparam logic [1:0]    ERR_STRB = 2'b01;
    localparam logic [1:0]    ERR_TO   = 2'b10;
    localparam logic [1:0]    ERR_LEN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_TURN,
        S_ERR
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       tm1n;
        logic       tm0n;
        logic [1:0] ad_lo;
    } enc_t;

    function automatic enc_t encode(input logic [3:0] strb);
        enc_t e;
        e.legal = 1'b1;
        e.tm1n  = 1'b0;
        e.tm0n  = 1'b0;
        e.ad_lo = 2'b00;
        case (strb)
            4'b0000: begin e.tm1n = 1'b1; e.tm0n = 1'b1; end
            4'b0001: e.ad_lo = 2'b00;
            4'b0010: e.ad_lo = 2'b10;
            4'b0100: e.ad_lo = 2'b01;
            4'b1000: e.ad_lo = 2'b11;
            4'b0011: begin e.tm0n = 1'b1; e.ad_lo = 2'b01; end
            4'b1100: begin e.tm0n = 1'b1; e.ad_lo = 2'b11; end
            4'b1111: begin e.tm0n = 1'b1; e.ad_lo = 2'b00; end
            default: begin e.legal = 1'b0; e.tm1n = 1'b1; e.tm0n = 1'b1; end
        endcase
        return e;
    endfunction

    state_t        state_q, state_d;
    logic [31:0]   wdata_q;
    logic [LW-1:0] len_q;
    logic          wr_q;
    logic [LW-1:0] beat_q;
    logic [TW-1:0] to_q;

    logic          adrcy_q, adrcy_d;
    logic [31:0]   ad_q, ad_d;
    logic          oe_q, oe_d;
    logic          tm1n_q, tm1n_d;
    logic          tm0n_q, tm0n_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    err_q, err_d;
    logic          last_q, last_d;

    enc_t          req_enc;
    logic          req_is_wr;
    logic          req_bad;
    logic [1:0]    req_err;
    logic [31:0]   addr_ad;
    logic          accept;
    logic          ack;
    logic          last_beat;
    logic          timeout;
    logic          unused_addr_lo;

    assign req_ready      = (state_q == S_IDLE);
    assign accept         = req_valid && req_ready;
    assign req_enc        = encode(req_write);
    assign req_is_wr      = |req_write;
    assign req_bad        = !req_enc.legal || (req_is_wr && (|req_len));
    assign req_err        = req_enc.legal ? ERR_LEN : ERR_STRB;
    assign ack            = (state_q == S_DATA) && !bus_ackn_i;
    assign last_beat      = ack && (beat_q == len_q);
    assign timeout        = (state_q == S_DATA) && bus_ackn_i && (to_q == TO_LAST);
    assign unused_addr_lo = ^req_addr[1:0];

    always_comb begin
        addr_ad         = '0;
        addr_ad[AW-1:2] = req_addr[AW-1:2];
        addr_ad[1:0]    = req_enc.ad_lo;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: default every always_comb output up front so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = req_bad ? S_ERR : S_ADDR;
                end
            end
            S_ADDR:  state_d = S_DATA;
            S_DATA: begin
                if (last_beat || timeout) begin
                    state_d = S_TURN;
                end
            end
            S_TURN:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in that state;
    // ADDR is only entered from IDLE, so it takes the request straight from the port.
    always_comb begin
        adrcy_d     = 1'b0;
        ad_d        = '0;
        oe_d        = 1'b0;
        tm1n_d      = 1'b1;
        tm0n_d      = 1'b1;
        rsp_valid_d = 1'b0;
        rdata_d     = '0;
        err_d       = ERR_OK;
        last_d      = 1'b0;
        case (state_d)
            S_ADDR: begin
                adrcy_d = 1'b1;
                oe_d    = 1'b1;
                ad_d    = addr_ad;
                tm1n_d  = req_enc.tm1n;
                tm0n_d  = req_enc.tm0n;
            end
            S_DATA: begin
                oe_d   = wr_q;
                ad_d   = wr_q ? wdata_q : '0;
                tm1n_d = tm1n_q;
                tm0n_d = tm0n_q;
            end
            S_ERR: begin
                rsp_valid_d = 1'b1;
                last_d      = 1'b1;
                err_d       = req_err;
            end
            default: ;
        endcase
        if (ack) begin
            rsp_valid_d = 1'b1;
            rdata_d     = wr_q ? '0 : bus_ad_i;
            last_d      = last_beat;
        end
        if (timeout) begin
            rsp_valid_d = 1'b1;
            err_d       = ERR_TO;
            last_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adrcy_q     <= 1'b0;
            ad_q        <= '0;
            oe_q        <= 1'b0;
            tm1n_q      <= 1'b1;
            tm0n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= ERR_OK;
            last_q      <= 1'b0;
        end else begin
            adrcy_q     <= adrcy_d;
            ad_q        <= ad_d;
            oe_q        <= oe_d;
            tm1n_q      <= tm1n_d;
            tm0n_q      <= tm0n_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            last_q      <= last_d;
        end
    end

    // Beat and timeout counters; the timeout count restarts on every ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
            beat_q  <= '0;
            to_q    <= '0;
        end else if (accept) begin
            wdata_q <= req_wdata;
            len_q   <= req_len;
            wr_q    <= req_is_wr;
            beat_q  <= '0;
            to_q    <= '0;
        end else if (ack) begin
            beat_q  <= beat_q + LW'(1);
            to_q    <= '0;
        end else if (state_q == S_DATA) begin
            to_q    <= to_q + TW'(1);
        end
    end

    assign bus_adrcy_o = adrcy_q;
    assign bus_ad_o    = ad_q;
    assign bus_ad_oe   = oe_q;
    assign bus_tm1n_o  = tm1n_q;
    assign bus_tm0n_o  = tm0n_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_last    = last_q;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Directed bench for cpu_bus_seq: single-transfer vector table plus hand-timed
// burst, timeout, back-to-back and mid-burst reset sequences.
`timescale 1ns/1ps
module tb_cpu_bus_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_len;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        rsp_last;
    logic        bus_adrcy_o;
    logic [31:0] bus_ad_o;
    logic        bus_ad_oe;
    logic [31:0] bus_ad_i;
    logic        bus_tm1n_o;
    logic        bus_tm0n_o;
    logic        bus_ackn_i;

    int checks = 0;
    int errors = 0;

    cpu_bus_seq #(.AW(32), .BURST_MAX(4), .TO_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_len    (req_len),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_last   (rsp_last),
        .bus_adrcy_o(bus_adrcy_o),
        .bus_ad_o   (bus_ad_o),
        .bus_ad_oe  (bus_ad_oe),
        .bus_ad_i   (bus_ad_i),
        .bus_tm1n_o (bus_tm1n_o),
        .bus_tm0n_o (bus_tm0n_o),
        .bus_ackn_i (bus_ackn_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  strb;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  exp_err;
        logic        exp_tm1n;
        logic        exp_tm0n;
        logic [31:0] exp_ad;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adrcy"}, bus_adrcy_o, 0);
        check({tag, "_ad"}, bus_ad_o, 0);
        check({tag, "_oe"}, bus_ad_oe, 0);
        check({tag, "_tm1n"}, bus_tm1n_o, 1);
        check({tag, "_tm0n"}, bus_tm0n_o, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rdata"}, rsp_rdata, 0);
        check({tag, "_err"}, rsp_err, 0);
        check({tag, "_last"}, rsp_last, 0);
        check({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic present(input logic [3:0] strb, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = strb;
        req_len   = len;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Single transfer with ack in the first DATA cycle, or an error response.
    task automatic run_vec(input vec_t v);
        logic wr;
        wr = (v.strb != 4'b0000);
        check("v_idle_ready", req_ready, 1);
        present(v.strb, v.len, v.addr, v.wdata);
        tick();
        req_valid = 1'b0;
        if (v.exp_err != 2'b00) begin
            check("e_adrcy", bus_adrcy_o, 0);
            check("e_oe", bus_ad_oe, 0);
            check("e_valid", rsp_valid, 1);
            check("e_code", rsp_err, v.exp_err);
            check("e_last", rsp_last, 1);
            check("e_rdata", rsp_rdata, 0);
            tick();
            check("e_back_idle", req_ready, 1);
            check("e_valid_drop", rsp_valid, 0);
            check("e_adrcy2", bus_adrcy_o, 0);
        end else begin
            check("a_adrcy", bus_adrcy_o, 1);
            check("a_oe", bus_ad_oe, 1);
            check("a_ad", bus_ad_o, v.exp_ad);
            check("a_tm1n", bus_tm1n_o, v.exp_tm1n);
            check("a_tm0n", bus_tm0n_o, v.exp_tm0n);
            check("a_ready", req_ready, 0);
            tick();
            check("d_adrcy", bus_adrcy_o, 0);
            check("d_oe", bus_ad_oe, wr);
            check("d_ad", bus_ad_o, wr ? v.wdata : 32'h0);
            check("d_tm1n", bus_tm1n_o, v.exp_tm1n);
            check("d_tm0n", bus_tm0n_o, v.exp_tm0n);
            check("d_no_rsp", rsp_valid, 0);
            bus_ackn_i = 1'b0;
            bus_ad_i   = v.rdata;
            tick();
            bus_ackn_i = 1'b1;
            bus_ad_i   = 32'h0;
            check("t_rsp_valid", rsp_valid, 1);
            check("t_rsp_err", rsp_err, 0);
            check("t_rsp_last", rsp_last, 1);
            check("t_rsp_rdata", rsp_rdata, wr ? 32'h0 : v.rdata);
            check("t_oe", bus_ad_oe, 0);
            check("t_tm1n", bus_tm1n_o, 1);
            check("t_tm0n", bus_tm0n_o, 1);
            check("t_ready", req_ready, 0);
            tick();
            check("i_ready", req_ready, 1);
            check("i_rsp_drop", rsp_valid, 0);
        end
    endtask

    initial begin
        // strb, len, addr, wdata, bus rdata, err, tm1n, tm0n, ADDR-cycle ad
        vecs[0]  = '{4'b0100, 2'd0, 32'h1000_0013, 32'hAABB_CCDD, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 32'h1000_0011};
        vecs[1]  = '{4'b0000, 2'd0, 32'h2000_0008, 32'h0,         32'h1234_5678, 2'b00, 1'b1, 1'b1, 32'h2000_0008};
        vecs[2]  = '{4'b0001, 2'd0, 32'h4000_0002, 32'h1111_1111, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 32'h4000_0000};
        vecs[3]  = '{4'b0010, 2'd0, 32'h4000_0001, 32'h2222_2222, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 32'h4000_0002};
        vecs[4]  = '{4'b1000, 2'd0, 32'h4000_000C, 32'h3333_3333, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 32'h4000_000F};
        vecs[5]  = '{4'b0011, 2'd0, 32'h5000_0003, 32'h4444_4444, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1, 32'h5000_0001};
        vecs[6]  = '{4'b1100, 2'd0, 32'h5000_0006, 32'h5555_5555, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1, 32'h5000_0007};
        vecs[7]  = '{4'b1111, 2'd0, 32'hFFFF_FFFF, 32'h6666_6666, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFC};
        vecs[8]  = '{4'b0101, 2'd0, 32'h7000_0000, 32'h0,         32'h0,         2'b01, 1'b1, 1'b1, 32'h0};
        vecs[9]  = '{4'b1111, 2'd2, 32'h7000_0004, 32'h7777_7777, 32'h0,         2'b11, 1'b1, 1'b1, 32'h0};
        vecs[10] = '{4'b0110, 2'd3, 32'h7000_0008, 32'h0,         32'h0,         2'b01, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{4'b0111, 2'd0, 32'h7000_000C, 32'h0,         32'h0,         2'b01, 1'b1, 1'b1, 32'h0};
        vecs[12] = '{4'b1001, 2'd0, 32'h7000_0010, 32'h0,         32'h0,         2'b01, 1'b1, 1'b1, 32'h0};
        vecs[13] = '{4'b0000, 2'd0, 32'h0000_0003, 32'h0,         32'hFFFF_FFFF, 2'b00, 1'b1, 1'b1, 32'h0000_0000};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 4'b0000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_len    = 2'd0;
        bus_ad_i   = 32'h0;
        bus_ackn_i = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        tick();
        check_reset_outputs("post_rst");

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Read burst of 4 with two wait states before beat 2.
        present(4'b0000, 2'd3, 32'h2000_0000, 32'h0);
        tick();
        req_valid = 1'b0;
        check("b_adrcy", bus_adrcy_o, 1);
        check("b_ad", bus_ad_o, 32'h2000_0000);
        check("b_tm1n", bus_tm1n_o, 1);
        check("b_tm0n", bus_tm0n_o, 1);
        tick();
        check("b_d_oe", bus_ad_oe, 0);
        bus_ackn_i = 1'b0; bus_ad_i = 32'd1;
        tick();
        check("b_r1_valid", rsp_valid, 1);
        check("b_r1_data", rsp_rdata, 1);
        check("b_r1_last", rsp_last, 0);
        check("b_r1_adrcy", bus_adrcy_o, 0);
        bus_ackn_i = 1'b1;
        tick();
        check("b_w1_no_rsp", rsp_valid, 0);
        tick();
        check("b_w2_no_rsp", rsp_valid, 0);
        check("b_w2_adrcy", bus_adrcy_o, 0);
        bus_ackn_i = 1'b0; bus_ad_i = 32'd2;
        tick();
        check("b_r2_valid", rsp_valid, 1);
        check("b_r2_data", rsp_rdata, 2);
        check("b_r2_last", rsp_last, 0);
        bus_ad_i = 32'd3;
        tick();
        check("b_r3_valid", rsp_valid, 1);
        check("b_r3_data", rsp_rdata, 3);
        check("b_r3_last", rsp_last, 0);
        bus_ad_i = 32'd4;
        tick();
        bus_ackn_i = 1'b1; bus_ad_i = 32'h0;
        check("b_r4_valid", rsp_valid, 1);
        check("b_r4_data", rsp_rdata, 4);
        check("b_r4_last", rsp_last, 1);
        check("b_turn_oe", bus_ad_oe, 0);
        check("b_turn_ready", req_ready, 0);
        tick();
        check("b_idle_ready", req_ready, 1);
        check("b_idle_no_rsp", rsp_valid, 0);

        // Timeout with no ack at all: 16 silent DATA cycles, then err 10.
        present(4'b0000, 2'd0, 32'h6000_0000, 32'h0);
        tick();
        req_valid = 1'b0;
        check("to_adrcy", bus_adrcy_o, 1);
        for (int c = 0; c < 16; c++) begin
            tick();
            check("to_wait_no_rsp", rsp_valid, 0);
            check("to_wait_adrcy", bus_adrcy_o, 0);
        end
        tick();
        check("to_valid", rsp_valid, 1);
        check("to_err", rsp_err, 2'b10);
        check("to_last", rsp_last, 1);
        check("to_rdata", rsp_rdata, 0);
        check("to_turn_oe", bus_ad_oe, 0);
        check("to_turn_tm1n", bus_tm1n_o, 1);
        check("to_turn_ready", req_ready, 0);
        tick();
        check("to_idle_ready", req_ready, 1);
        check("to_idle_no_rsp", rsp_valid, 0);

        // Timeout after one returned beat: the counter restarts on ack.
        present(4'b0000, 2'd1, 32'h6000_0010, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        bus_ackn_i = 1'b0; bus_ad_i = 32'h0000_00A5;
        tick();
        bus_ackn_i = 1'b1; bus_ad_i = 32'h0;
        check("pt_beat_valid", rsp_valid, 1);
        check("pt_beat_data", rsp_rdata, 32'hA5);
        check("pt_beat_last", rsp_last, 0);
        for (int c = 0; c < 15; c++) begin
            tick();
            check("pt_wait_no_rsp", rsp_valid, 0);
        end
        tick();
        check("pt_to_valid", rsp_valid, 1);
        check("pt_to_err", rsp_err, 2'b10);
        check("pt_to_last", rsp_last, 1);
        tick();
        check("pt_idle_ready", req_ready, 1);

        // Read then write back-to-back; the write is held pending from the read's ADDR.
        present(4'b0000, 2'd0, 32'h3000_0004, 32'h0);
        tick();
        present(4'b1111, 2'd0, 32'h3000_0008, 32'hCAFE_F00D);
        check("bb_r_adrcy", bus_adrcy_o, 1);
        check("bb_r_ready", req_ready, 0);
        tick();
        check("bb_r_data_oe", bus_ad_oe, 0);
        bus_ackn_i = 1'b0; bus_ad_i = 32'h0BAD_F00D;
        tick();
        bus_ackn_i = 1'b1; bus_ad_i = 32'h0;
        check("bb_turn_oe", bus_ad_oe, 0);
        check("bb_turn_adrcy", bus_adrcy_o, 0);
        check("bb_turn_tm1n", bus_tm1n_o, 1);
        check("bb_turn_tm0n", bus_tm0n_o, 1);
        check("bb_turn_rdata", rsp_rdata, 32'h0BAD_F00D);
        check("bb_turn_ready", req_ready, 0);
        tick();
        check("bb_idle_oe", bus_ad_oe, 0);
        check("bb_idle_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("bb_w_adrcy", bus_adrcy_o, 1);
        check("bb_w_oe", bus_ad_oe, 1);
        check("bb_w_ad", bus_ad_o, 32'h3000_0008);
        check("bb_w_tm1n", bus_tm1n_o, 0);
        check("bb_w_tm0n", bus_tm0n_o, 1);
        tick();
        check("bb_w_data", bus_ad_o, 32'hCAFE_F00D);
        bus_ackn_i = 1'b0;
        tick();
        bus_ackn_i = 1'b1;
        check("bb_w_rsp", rsp_valid, 1);
        check("bb_w_rsp_rdata", rsp_rdata, 0);
        check("bb_w_rsp_last", rsp_last, 1);
        tick();
        check("bb_w_idle", req_ready, 1);

        // Reset during beat 2 of a burst: the pending ack is dropped.
        present(4'b0000, 2'd3, 32'h2000_0100, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        bus_ackn_i = 1'b0; bus_ad_i = 32'h1;
        tick();
        check("rb_beat1", rsp_valid, 1);
        bus_ad_i = 32'h2;
        rst = 1'b1;
        tick();
        check_reset_outputs("rb_reset");
        rst = 1'b0;
        bus_ackn_i = 1'b1; bus_ad_i = 32'h0;
        tick();
        check("rb_quiet_rsp", rsp_valid, 0);
        check("rb_quiet_adrcy", bus_adrcy_o, 0);
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
